down_count_checker: RTL
=======================

Name: down_count_checker

Overview:
- Downstream monitor for the 4-bit synchronous down counter.
- Samples the counter output every clock and confirms that each sample equals the previous one minus 1, modulo 2^WIDTH.
- Reports lock status, single-cycle error pulses, a saturating error count and a wrap count.
- Sits beside the Tester in the counter bench and can also stay in silicon as a self-check.

Parameters:
- WIDTH, 4, width of the monitored count.
- ERR_W, 8, width of the saturating error counter.
- WRAP_W, 8, width of the wrap counter (rolls over, does not saturate).
- LOCK_LEN, 4, consecutive correct decrements needed to assert lock (range 1..15).

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; when 0 all state holds.
- clr  input  1  synchronous clear of counters and state; overrides en.
- count_in  input  WIDTH  counter output being checked.
- locked  output  1  high while tracking a valid down sequence.
- err  output  1  one-cycle pulse on a mismatch while locked.
- err_count  output  ERR_W  number of errors, saturating at all-ones.
- wrap_count  output  WRAP_W  number of verified 0 -> max transitions while locked.
- expected  output  WIDTH  value required on the next enabled sample, which is prev-1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - locked=0, err=0, err_count=0, wrap_count=0, expected=0.
  - Internal prev=0 and good_run=0.
- All outputs are registered. A decision on the sample taken at edge k is visible immediately after edge k.
- clr=1 at an edge:
  - Same values as reset, but synchronous.
  - Has priority over en and over any compare.
- en=0: all registers hold, err is forced to 0 the next cycle, and no compare takes place.
- When en=1, define match = (count_in == prev - 1 mod 2^WIDTH). 0 - 1 = 2^WIDTH - 1, so it wraps.
- On every enabled edge, prev <= count_in and expected <= count_in - 1 (mod), in every state.
- States:
  - IDLE: the first enabled sample only loads prev. No compare. Next state is ACQ with good_run=0.
  - ACQ:
    - On match: good_run++.
    - If good_run+1 == LOCK_LEN: go to LOCKED, locked<=1, good_run<=0.
    - On mismatch: good_run<=0, stay in ACQ. err is not pulsed and err_count is unchanged.
  - LOCKED:
    - On match: stay. If prev==0 (so count_in==max), wrap_count++ with natural rollover.
    - On mismatch: err<=1 for exactly one cycle; err_count++ unless already all-ones; locked<=0; good_run<=0; go to ACQ.
- err is 0 on every edge other than a LOCKED mismatch edge. Back-to-back mismatches give one pulse only, because the second mismatch lands in ACQ.
- A stalled counter (count_in == prev) is a mismatch.
- A wrap seen during ACQ counts toward good_run but does not increment wrap_count.
- Reset asserted mid-operation clears everything immediately. No output glitches are permitted other than the asynchronous clear itself.
- Width rules:
  - All count arithmetic is WIDTH bits, modulo.
  - good_run is 4 bits.
  - Counter increments never widen.

Test Plan:
- Reset, then count_in 15,14,13,12,11 with en=1 -> locked rises after the edge sampling 11 (4 matches). err=0. expected=10.
- Locked, continue 2,1,0,15,14 -> wrap_count goes 0 -> 1 on the 0 -> 15 edge. locked stays 1. err_count=0.
- Locked at 9, present 9 (stall) then 5 -> exactly one err pulse on the stall edge. err_count=1. locked=0. After 4,3,2,1, locked=1 again.
- Force 300 lock/mismatch cycles with ERR_W=8 -> err_count saturates at 255 and stays there. err still pulses on each mismatch.
- Locked with en=0 for 5 cycles while count_in changes arbitrarily -> outputs frozen, no err. Resume with en=1 and the correct next value -> stays locked.
- Locked with wrap_count=3:
  - clr=1 for one edge -> all outputs 0, state IDLE.
  - rst pulsed low between edges -> outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/down_count_checker.sv
// Monitor for a free-running down counter: tracks lock on a valid prev-1 sequence,
// pulses err on a mismatch while locked, and counts errors (saturating) and wraps.
module down_count_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  expected
);

  localparam int unsigned RUN_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  prev, prev_n;
  logic [RUN_W-1:0]  good_run, good_run_n;
  logic              locked_n, err_n;
  logic [ERR_W-1:0]  err_count_n;
  logic [WRAP_W-1:0] wrap_count_n;
  logic [WIDTH-1:0]  expected_n;
  logic              match_c;

  assign match_c = (count_in == WIDTH'(prev - WIDTH'(1)));

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev       <= '0;
      good_run   <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      expected   <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      good_run   <= good_run_n;
      locked     <= locked_n;
      err        <= err_n;
      err_count  <= err_count_n;
      wrap_count <= wrap_count_n;
      expected   <= expected_n;
    end
  end

  // Next-state and next-output logic; err defaults low so it can only pulse
  always_comb begin
    state_n      = state;
    prev_n       = prev;
    good_run_n   = good_run;
    locked_n     = locked;
    err_n        = 1'b0;
    err_count_n  = err_count;
    wrap_count_n = wrap_count;
    expected_n   = expected;

    if (clr) begin
      state_n      = IDLE;
      prev_n       = '0;
      good_run_n   = '0;
      locked_n     = 1'b0;
      err_count_n  = '0;
      wrap_count_n = '0;
      expected_n   = '0;
    end else if (en) begin
      prev_n     = count_in;
      expected_n = WIDTH'(count_in - WIDTH'(1));
      case (state)
        IDLE: begin
          state_n    = ACQ;
          good_run_n = '0;
        end
        ACQ: begin
          if (match_c) begin
            if (RUN_W'(good_run + RUN_W'(1)) == RUN_W'(LOCK_LEN)) begin
              state_n    = LOCKED;
              locked_n   = 1'b1;
              good_run_n = '0;
            end else begin
              good_run_n = RUN_W'(good_run + RUN_W'(1));
            end
          end else begin
            good_run_n = '0;
          end
        end
        LOCKED: begin
          if (match_c) begin
            if (prev == '0) wrap_count_n = WRAP_W'(wrap_count + WRAP_W'(1));
          end else begin
            err_n      = 1'b1;
            locked_n   = 1'b0;
            good_run_n = '0;
            state_n    = ACQ;
            if (err_count != '1) err_count_n = ERR_W'(err_count + ERR_W'(1));
          end
        end
        default: begin
          state_n    = IDLE;
          good_run_n = '0;
          locked_n   = 1'b0;
        end
      endcase
    end
  end

endmodule
